fft_result_serializer: RTL and testbench

- Output-side counterpart of the input deserializer. Captures one complete 16-point FFT result from the second-stage butterfly outputs: 16 real and 16 imaginary words.
- Streams the result as 32 WIDTH-bit words, one per accepted beat, over a valid/ready interface.
- Sits between the second radix-4 butterfly stage and the downstream consumer (output RAM, DAC or debug link).
- Provides frame boundaries, backpressure and overrun reporting.

---
 rtl/fft_result_serializer.sv | 122 ++++++++++++
 tb/tb_fft_result_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_serializer.sv
// fft_result_serializer
// Captures one complete 16-point FFT result (16 real and 16 imaginary words)
// and streams it as 32 WIDTH-bit beats over a valid/ready interface.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   load         capture request, taken only when in_ready is high
//   din_re       flattened real results, bin n at [n*WIDTH +: WIDTH]
//   din_im       flattened imaginary results, same packing
//   in_ready     a load is accepted this cycle (combinational from dout_ready)
//   dout         serial output word
//   dout_valid   dout holds a valid word
//   dout_ready   downstream accepts the word this cycle
//   dout_first   beat 0 of a frame
//   dout_last    beat 31 of a frame
//   busy         a frame is held or being sent
//   overrun      sticky, a load arrived while in_ready was low
//   overrun_clr  synchronous clear of overrun (a same-cycle set wins)
//
// State  | meaning
// IDLE   | no frame held, ready to capture
// SEND   | frame held, presenting beat r_cnt
module fft_result_serializer #(
  parameter int WIDTH      = 16,
  parameter int ORDER_MODE = 0,
  parameter int INTERLEAVE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [16*WIDTH-1:0]   din_re,
  input  logic [16*WIDTH-1:0]   din_im,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_first,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]          r_state;
  logic [4:0]          r_cnt;
  logic [16*WIDTH-1:0] r_re;
  logic [16*WIDTH-1:0] r_im;
  logic                r_overrun;

  logic                w_send;
  logic                w_hs;
  logic                w_accept;
  logic [3:0]          w_idx;
  logic [3:0]          w_bin;
  logic                w_sel_im;
  logic [WIDTH-1:0]    w_word;

  assign w_send   = (r_state == S_SEND);
  assign w_hs     = w_send && dout_ready;
  // Accepting on the final handshake lets back-to-back frames run without a bubble.
  assign in_ready = (r_state == S_IDLE) || (w_send && (r_cnt == 5'd31) && dout_ready);
  assign w_accept = load && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_re    <= '0;
      r_im    <= '0;
    end else if (w_accept) begin
      r_re    <= din_re;
      r_im    <= din_im;
      r_state <= S_SEND;
      r_cnt   <= 5'd0;
    end else if (w_hs) begin
      if (r_cnt == 5'd31) begin
        r_state <= S_IDLE;
        r_cnt   <= 5'd0;
      end else begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (load && !in_ready) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  // Beat -> (real/imag, bin). Digit reversal swaps the two base-4 digits of the index.
  always_comb begin
    w_idx    = r_cnt[3:0];
    w_sel_im = r_cnt[4];
    if (INTERLEAVE != 0) begin
      w_idx    = r_cnt[4:1];
      w_sel_im = r_cnt[0];
    end
    w_bin = w_idx;
    if (ORDER_MODE != 0) begin
      w_bin = {w_idx[1:0], w_idx[3:2]};
    end
  end

  assign w_word = w_sel_im ? r_im[w_bin*WIDTH +: WIDTH] : r_re[w_bin*WIDTH +: WIDTH];

  assign dout       = w_send ? w_word : '0;
  assign dout_valid = w_send;
  assign dout_first = w_send && (r_cnt == 5'd0);
  assign dout_last  = w_send && (r_cnt == 5'd31);
  assign busy       = w_send;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_fft_result_serializer.sv
module tb_fft_result_serializer;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           load = 1'b0;
  logic [16*W-1:0] din_re = '0;
  logic [16*W-1:0] din_im = '0;
  logic           dout_ready = 1'b0;
  logic           overrun_clr = 1'b0;

  logic           in_ready_a, dout_valid_a, dout_first_a, dout_last_a, busy_a, overrun_a;
  logic [W-1:0]   dout_a;
  logic           in_ready_b, dout_valid_b, dout_first_b, dout_last_b, busy_b, overrun_b;
  logic [W-1:0]   dout_b;

  always #5 clk = ~clk;

  // a: capture order, re block then im block; b: digit-reversed, interleaved
  fft_result_serializer #(.WIDTH(W), .ORDER_MODE(0), .INTERLEAVE(0)) dut_a (
    .clk(clk), .reset(reset), .load(load), .din_re(din_re), .din_im(din_im),
    .in_ready(in_ready_a), .dout(dout_a), .dout_valid(dout_valid_a),
    .dout_ready(dout_ready), .dout_first(dout_first_a), .dout_last(dout_last_a),
    .busy(busy_a), .overrun(overrun_a), .overrun_clr(overrun_clr));

  fft_result_serializer #(.WIDTH(W), .ORDER_MODE(1), .INTERLEAVE(1)) dut_b (
    .clk(clk), .reset(reset), .load(load), .din_re(din_re), .din_im(din_im),
    .in_ready(in_ready_b), .dout(dout_b), .dout_valid(dout_valid_b),
    .dout_ready(dout_ready), .dout_first(dout_first_b), .dout_last(dout_last_b),
    .busy(busy_b), .overrun(overrun_b), .overrun_clr(overrun_clr));

  typedef struct {
    logic [W-1:0] w;
    int           beat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: beats still owed in the current frame, and the sticky flag
  int m_left = 0;
  bit m_ovr  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_of(input logic [16*W-1:0] v, input int n);
    return v[n*W +: W];
  endfunction

  task automatic push_frame(input logic [16*W-1:0] re, input logic [16*W-1:0] im);
    exp_t e;
    for (int c = 0; c < 32; c++) begin
      e.beat = c;
      e.w = (c < 16) ? word_of(re, c) : word_of(im, c - 16);
      qa.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      int bin;
      bin = 4 * (i % 4) + i / 4;
      e.beat = 2 * i;
      e.w = word_of(re, bin);
      qb.push_back(e);
      e.beat = 2 * i + 1;
      e.w = word_of(im, bin);
      qb.push_back(e);
    end
  endtask

  // One clock of stimulus; checks the combinational/status outputs against the model.
  task automatic cyc(input bit l, input bit r, input bit clr,
                     input logic [16*W-1:0] re, input logic [16*W-1:0] im);
    bit exp_ir;
    bit acc;
    bit hs;
    @(posedge clk);
    #1;
    load = l; dout_ready = r; overrun_clr = clr; din_re = re; din_im = im;
    exp_ir = (m_left == 0) || (m_left == 1 && r);
    @(negedge clk);
    chk("in_ready_a", in_ready_a, exp_ir);
    chk("in_ready_b", in_ready_b, exp_ir);
    chk("busy_a", busy_a, m_left != 0);
    chk("busy_b", busy_b, m_left != 0);
    chk("overrun_a", overrun_a, m_ovr);
    chk("overrun_b", overrun_b, m_ovr);
    acc = l && exp_ir;
    hs  = (m_left != 0) && r;
    if (hs) m_left--;
    if (acc) begin
      m_left = 32;
      push_frame(re, im);
    end
    if (l && !exp_ir) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  function automatic logic [16*W-1:0] ramp(input logic [W-1:0] base);
    logic [16*W-1:0] v;
    for (int n = 0; n < 16; n++) v[n*W +: W] = base + W'(n);
    return v;
  endfunction

  function automatic logic [16*W-1:0] rnd_vec();
    logic [16*W-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout_a"}, dout_a, 0);
    chk({tag, "_valid_a"}, dout_valid_a, 0);
    chk({tag, "_first_a"}, dout_first_a, 0);
    chk({tag, "_last_a"}, dout_last_a, 0);
    chk({tag, "_busy_a"}, busy_a, 0);
    chk({tag, "_ovr_a"}, overrun_a, 0);
    chk({tag, "_inrdy_a"}, in_ready_a, 1);
    chk({tag, "_dout_b"}, dout_b, 0);
    chk({tag, "_valid_b"}, dout_valid_b, 0);
    chk({tag, "_busy_b"}, busy_b, 0);
    chk({tag, "_inrdy_b"}, in_ready_b, 1);
  endtask

  // monitors: pop on every handshake seen at the negedge, and check stall stability
  logic [W-1:0] prev_dout_a, prev_dout_b;
  bit prev_stall_a = 1'b0, prev_stall_b = 1'b0;
  bit prev_first_a, prev_last_a, prev_first_b, prev_last_b;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall_a) begin
        chk("stall_valid_a", dout_valid_a, 1);
        chk("stall_dout_a", dout_a, prev_dout_a);
        chk("stall_first_a", dout_first_a, prev_first_a);
        chk("stall_last_a", dout_last_a, prev_last_a);
      end
      if (dout_valid_a && dout_ready) begin
        if (qa.size() == 0) begin
          chk("unexpected_beat_a", dout_a, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("dout_a", dout_a, e.w);
          chk("first_a", dout_first_a, e.beat == 0);
          chk("last_a", dout_last_a, e.beat == 31);
        end
      end
      prev_stall_a = dout_valid_a && !dout_ready;
      prev_dout_a  = dout_a;
      prev_first_a = dout_first_a;
      prev_last_a  = dout_last_a;
    end else begin
      prev_stall_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall_b) begin
        chk("stall_valid_b", dout_valid_b, 1);
        chk("stall_dout_b", dout_b, prev_dout_b);
        chk("stall_first_b", dout_first_b, prev_first_b);
        chk("stall_last_b", dout_last_b, prev_last_b);
      end
      if (dout_valid_b && dout_ready) begin
        if (qb.size() == 0) begin
          chk("unexpected_beat_b", dout_b, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("dout_b", dout_b, e.w);
          chk("first_b", dout_first_b, e.beat == 0);
          chk("last_b", dout_last_b, e.beat == 31);
        end
      end
      prev_stall_b = dout_valid_b && !dout_ready;
      prev_dout_b  = dout_b;
      prev_first_b = dout_first_b;
      prev_last_b  = dout_last_b;
    end else begin
      prev_stall_b = 1'b0;
    end
  end

  logic [16*W-1:0] re0, im0;

  initial begin
    re0 = ramp(16'h0100);
    im0 = ramp(16'h0200);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // plain frame, always ready
    cyc(1, 1, 0, re0, im0);
    for (int i = 0; i < 34; i++) cyc(0, 1, 0, rnd_vec(), rnd_vec());
    chk("valid_after_frame_a", dout_valid_a, 0);
    chk("valid_after_frame_b", dout_valid_b, 0);
    chk("drained_1", qa.size() + qb.size(), 0);

    // same frame with ready pattern 1,0,0,1
    cyc(1, 1, 0, re0, im0);
    for (int i = 0; i < 80; i++) cyc(0, (i % 4 == 0) || (i % 4 == 3), 0, rnd_vec(), rnd_vec());
    chk("drained_2", qa.size() + qb.size(), 0);

    // overrun mid-frame, then back-to-back frame on beat 31
    cyc(1, 1, 0, re0, im0);
    for (int g = 0; g < 100 && m_left != 22; g++) cyc(0, 1, 0, re0, im0);
    cyc(1, 1, 0, ramp(16'h7700), ramp(16'h8800));
    chk("ovr_beat10_a", overrun_a, 0);
    cyc(0, 1, 0, re0, im0);
    chk("ovr_set_a", overrun_a, 1);
    chk("ovr_set_b", overrun_b, 1);
    for (int g = 0; g < 100 && m_left != 1; g++) cyc(0, 1, 0, re0, im0);
    chk("beat31_reached", m_left, 1);
    cyc(1, 1, 0, ramp(16'h0300), ramp(16'h0400));
    cyc(0, 1, 0, re0, im0);
    chk("no_bubble_valid_a", dout_valid_a, 1);
    chk("no_bubble_first_a", dout_first_a, 1);
    chk("no_bubble_dout_a", dout_a, 16'h0300);
    cyc(0, 1, 1, re0, im0);
    cyc(0, 1, 0, re0, im0);
    chk("ovr_cleared_a", overrun_a, 0);
    for (int i = 0; i < 35; i++) cyc(0, 1, 0, re0, im0);
    chk("drained_3", qa.size() + qb.size(), 0);

    // set wins over clear in the same cycle
    cyc(1, 1, 0, re0, im0);
    cyc(1, 1, 1, re0, im0);
    cyc(0, 1, 0, re0, im0);
    chk("set_wins_a", overrun_a, 1);
    cyc(0, 1, 1, re0, im0);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 10) == 0, ($urandom % 4) != 0, ($urandom % 20) == 0, rnd_vec(), rnd_vec());
    for (int i = 0; i < 80; i++) cyc(0, 1, 1, rnd_vec(), rnd_vec());
    chk("drained_rand", qa.size() + qb.size(), 0);

    // reset in the middle of a frame
    cyc(1, 1, 0, re0, im0);
    for (int g = 0; g < 100 && m_left != 15; g++) cyc(0, 1, 0, re0, im0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    qa.delete();
    qb.delete();
    m_left = 0;
    m_ovr  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 1, 0, ramp(16'h0500), ramp(16'h0600));
    cyc(0, 1, 0, re0, im0);
    chk("restart_first_a", dout_first_a, 1);
    chk("restart_dout_a", dout_a, 16'h0500);
    chk("restart_dout_b", dout_b, 16'h0500);
    for (int i = 0; i < 35; i++) cyc(0, 1, 0, re0, im0);
    chk("drained_end", qa.size() + qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
